// File: rtl/serial_n_adder.sv
// serial_n_adder: digit-serial signed adder.
// Adds two N-bit two's-complement operands plus carry-in, W bits per clock,
// over K = N/W cycles, with valid/ready handshakes on both sides.
// Reports the modulo-2^N sum, the unsigned carry-out and signed overflow.
//
// Optional build macro: SERIAL_N_ADDER_SAT_EN
//   defined   -> on overflow S is replaced by the saturated extreme
//   undefined -> S is always the wrapped sum (no saturation logic)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | adding one W-bit digit per cycle, LSB digit first
// DONE  | result held on S/c_out/ovf until out_ready

module serial_n_adder #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         c_out,
    output logic         ovf
);

    localparam int K  = N / W;
    localparam int CW = $clog2(K + 1);

    // Reject illegal width combinations at elaboration time.
    if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
        $error("serial_n_adder: need N >= 2, 1 <= W <= N and N %% W == 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  s_reg;
    logic          carry;
    logic          sign_a;
    logic          sign_b;
    logic          c_out_reg;
    logic          ovf_reg;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          last_digit;
    logic [W:0]    digit_sum;
    logic [N-1:0]  s_shift;
    logic [N-1:0]  a_next;
    logic [N-1:0]  b_next;
    logic          ovf_calc;

`ifdef SERIAL_N_ADDER_SAT_EN
    logic [N-1:0]  sat_value;
`endif

    // Handshake signals are pure decodes of the registered state.
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt == CW'(K - 1));

    assign S     = s_reg;
    assign c_out = c_out_reg;
    assign ovf   = ovf_reg;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, count digits in BUSY, hold in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One digit of the ripple: low W bits of each operand plus the running carry.
    always_comb begin
        digit_sum = {1'b0, a_reg[W-1:0]} + {1'b0, b_reg[W-1:0]} + {{W{1'b0}}, carry};
    end

    // Shift paths; W==N has nothing left to shift in after the single digit.
    if (W == N) begin : g_single_digit
        // Whole operand is one digit, so the sum replaces S and operands empty out.
        always_comb begin
            s_shift = digit_sum[W-1:0];
            a_next  = '0;
            b_next  = '0;
        end
    end else begin : g_multi_digit
        // New digit enters at the top of S; operands move down by one digit.
        always_comb begin
            s_shift = {digit_sum[W-1:0], s_reg[N-1:W]};
            a_next  = {{W{1'b0}}, a_reg[N-1:W]};
            b_next  = {{W{1'b0}}, b_reg[N-1:W]};
        end
    end

    // Overflow uses the signs captured at acceptance, since a_reg/b_reg have
    // been shifted away by the time the final digit is produced.
    always_comb begin
        ovf_calc = (sign_a == sign_b) && (s_shift[N-1] != sign_a);
    end

`ifdef SERIAL_N_ADDER_SAT_EN
    // Saturated extreme selected by the common operand sign.
    always_comb begin
        sat_value = sign_a ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif

    // Operand capture, digit-serial accumulation and result latching.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry     <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        carry     <= c_in;
                        sign_a    <= A[N-1];
                        sign_b    <= B[N-1];
                        c_out_reg <= 1'b0;
                        ovf_reg   <= 1'b0;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    a_reg <= a_next;
                    b_reg <= b_next;
                    carry <= digit_sum[W];
                    cnt   <= cnt + CW'(1);
                    s_reg <= s_shift;
                    if (last_digit) begin
                        c_out_reg <= digit_sum[W];
                        ovf_reg   <= ovf_calc;
`ifdef SERIAL_N_ADDER_SAT_EN
                        if (ovf_calc) begin
                            s_reg <= sat_value;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_n_adder.sv
// Testbench for serial_n_adder: directed cases on N=8/W=2, then random
// operands on N=8/W=8 and N=16/W=4 against an arithmetic reference model.

module tb_serial_n_adder;

    logic clk;
    logic rstn;

    int checks;
    int failures;

    // N=8, W=2
    logic       in_valid0, in_ready0, ci0, out_valid0, out_ready0, co0, ov0;
    logic [7:0] a0, b0, s0;
    // N=8, W=8
    logic       in_valid1, in_ready1, ci1, out_valid1, out_ready1, co1, ov1;
    logic [7:0] a1, b1, s1;
    // N=16, W=4
    logic        in_valid2, in_ready2, ci2, out_valid2, out_ready2, co2, ov2;
    logic [15:0] a2, b2, s2;

    serial_n_adder #(.N(8), .W(2)) u0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid0), .in_ready(in_ready0),
        .A(a0), .B(b0), .c_in(ci0), .out_valid(out_valid0), .out_ready(out_ready0),
        .S(s0), .c_out(co0), .ovf(ov0));

    serial_n_adder #(.N(8), .W(8)) u1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(a1), .B(b1), .c_in(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
        .S(s1), .c_out(co1), .ovf(ov1));

    serial_n_adder #(.N(16), .W(4)) u2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(a2), .B(b2), .c_in(ci2), .out_valid(out_valid2), .out_ready(out_ready2),
        .S(s2), .c_out(co2), .ovf(ov2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void ref_add(input int n, input longint unsigned a, input longint unsigned b,
                                    input bit ci, output longint unsigned s,
                                    output bit c, output bit o);
        longint unsigned full;
        longint sa, sb, sum, maxv, minv;
        full = a + b + longint'(ci);
        s    = full & ((64'd1 << n) - 1);
        c    = ((full >> n) & 64'd1) != 0;
        sa   = a[n-1] ? longint'(a) - (longint'(1) << n) : longint'(a);
        sb   = b[n-1] ? longint'(b) - (longint'(1) << n) : longint'(b);
        sum  = sa + sb + longint'(ci);
        maxv = (longint'(1) << (n - 1)) - 1;
        minv = -(longint'(1) << (n - 1));
        o    = (sum > maxv) || (sum < minv);
`ifdef SERIAL_N_ADDER_SAT_EN
        if (o) s = (sa >= 0) ? longint'(maxv) : (64'd1 << (n - 1));
`endif
    endfunction

    // Present operands to u0, then count edges until out_valid.
    task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic ci, input string tag);
        int n;
        @(negedge clk);
        a0 = a; b0 = b; ci0 = ci; in_valid0 = 1'b1;
        chk({tag, "_in_ready_pre"}, 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom); ci0 = 1'($urandom);
        n = 0;
        while (!out_valid0 && n < 20) begin
            chk({tag, "_in_ready_busy"}, 32'(in_ready0), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
    endtask

    task automatic result0(input logic [7:0] es, input logic ec, input logic eo, input string tag);
        chk({tag, "_S"}, 32'(s0), 32'(es));
        chk({tag, "_c_out"}, 32'(co0), 32'(ec));
        chk({tag, "_ovf"}, 32'(ov0), 32'(eo));
    endtask

    task automatic release0(input string tag);
        @(negedge clk);
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        out_ready0 = 1'b0;
        chk({tag, "_out_valid_after"}, 32'(out_valid0), 32'd0);
        chk({tag, "_in_ready_after"}, 32'(in_ready0), 32'd1);
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic ci);
        longint unsigned es;
        bit ec, eo;
        int n;
        ref_add(8, 64'(a), 64'(b), ci, es, ec, eo);
        @(negedge clk);
        a1 = a; b1 = b; ci1 = ci; in_valid1 = 1'b1;
        chk("w8_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("w8_latency", 32'(n), 32'd1);
        chk("w8_S", 32'(s1), 32'(es));
        chk("w8_c_out", 32'(co1), 32'(ec));
        chk("w8_ovf", 32'(ov1), 32'(eo));
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
    endtask

    task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic ci);
        longint unsigned es;
        bit ec, eo;
        int n;
        ref_add(16, 64'(a), 64'(b), ci, es, ec, eo);
        @(negedge clk);
        a2 = a; b2 = b; ci2 = ci; in_valid2 = 1'b1;
        chk("w4_in_ready", 32'(in_ready2), 32'd1);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("w4_latency", 32'(n), 32'd4);
        chk("w4_S", 32'(s2), 32'(es));
        chk("w4_c_out", 32'(co2), 32'(ec));
        chk("w4_ovf", 32'(ov2), 32'(eo));
        @(negedge clk);
        out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        out_ready2 = 1'b0;
    endtask

    initial begin
        logic [7:0] hold_s;
        logic       hold_c, hold_o;
        int         seen;

        checks = 0;
        failures = 0;
        rstn = 1'b0;
        in_valid0 = 0; out_ready0 = 0; a0 = 0; b0 = 0; ci0 = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; ci1 = 0;
        in_valid2 = 0; out_ready2 = 0; a2 = 0; b2 = 0; ci2 = 0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_S", 32'(s0), 32'd0);
        chk("rst_c_out", 32'(co0), 32'd0);
        chk("rst_ovf", 32'(ov0), 32'd0);
        rstn = 1'b1;

        issue0(8'd5, 8'd10, 1'b0, "add5_10");
        result0(8'd15, 1'b0, 1'b0, "add5_10");
        release0("add5_10");

        issue0(8'd30, 8'hF6, 1'b0, "add30_m10");
        result0(8'd20, 1'b1, 1'b0, "add30_m10");
        release0("add30_m10");

        issue0(8'd5, 8'd10, 1'b1, "add5_10_ci");
        result0(8'd16, 1'b0, 1'b0, "add5_10_ci");
        release0("add5_10_ci");

        issue0(8'd127, 8'd1, 1'b0, "pos_ovf");
`ifdef SERIAL_N_ADDER_SAT_EN
        result0(8'h7F, 1'b0, 1'b1, "pos_ovf");
`else
        result0(8'h80, 1'b0, 1'b1, "pos_ovf");
`endif
        release0("pos_ovf");

        issue0(8'h80, 8'hFF, 1'b0, "neg_ovf");
`ifdef SERIAL_N_ADDER_SAT_EN
        result0(8'h80, 1'b1, 1'b1, "neg_ovf");
`else
        result0(8'h7F, 1'b1, 1'b1, "neg_ovf");
`endif
        release0("neg_ovf");

        // Backpressure: -50 + 60 = 10 with carry-out, held for 3 cycles.
        issue0(8'hCE, 8'd60, 1'b0, "bp");
        result0(8'h0A, 1'b1, 1'b0, "bp");
        hold_s = s0; hold_c = co0; hold_o = ov0;
        repeat (3) begin
            @(negedge clk);
            in_valid0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom); ci0 = 1'($urandom);
            @(posedge clk);
            #1;
            chk("bp_S_stable", 32'(s0), 32'(hold_s));
            chk("bp_c_out_stable", 32'(co0), 32'(hold_c));
            chk("bp_ovf_stable", 32'(ov0), 32'(hold_o));
            chk("bp_out_valid_held", 32'(out_valid0), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready0), 32'd0);
        end
        @(negedge clk);
        in_valid0 = 1'b0;
        release0("bp");
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid0) seen = 1;
        end
        chk("bp_no_stray_result", 32'(seen), 32'd0);

        // Reset during the second BUSY cycle.
        @(negedge clk);
        a0 = 8'd100; b0 = 8'd27; ci0 = 1'b1; in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_in_ready_busy", 32'(in_ready0), 32'd0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready0), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid0), 32'd0);
        chk("mid_rst_S", 32'(s0), 32'd0);
        chk("mid_rst_c_out", 32'(co0), 32'd0);
        chk("mid_rst_ovf", 32'(ov0), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid0) seen = 1;
        end
        chk("mid_rst_no_out_valid", 32'(seen), 32'd0);
        chk("mid_rst_in_ready_idle", 32'(in_ready0), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run1(8'($urandom), 8'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 10; i++) begin
            run2(16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
